// File: rtl/mem_controller_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_controller_rr                                             |
// | Purpose  : Round-robin arbiter between NUM_CONSUMERS read/write          |
// |            requesters and NUM_CHANNELS global-memory channels, with an   |
// |            optional read-only mode and per-channel response timeout.     |
// | Ports    : clk, reset (sync, active-high)                                |
// |            consumer_* : per-consumer request/response, flattened lanes   |
// |            mem_*      : per-channel memory request/response, flattened   |
// |            consumer_error : raised with ready when a request timed out   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_controller_rr #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int NUM_CONSUMERS  = 4,
  parameter int NUM_CHANNELS   = 1,
  parameter int WRITE_ENABLE   = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [ADDR_BITS*NUM_CONSUMERS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [DATA_BITS*NUM_CONSUMERS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [ADDR_BITS*NUM_CONSUMERS-1:0] consumer_write_address,
  input  logic [DATA_BITS*NUM_CONSUMERS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CONSUMERS-1:0]           consumer_error,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [ADDR_BITS*NUM_CHANNELS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [DATA_BITS*NUM_CHANNELS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [ADDR_BITS*NUM_CHANNELS-1:0]  mem_write_address,
  output logic [DATA_BITS*NUM_CHANNELS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int c_PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_READ_WAITING   = 3'd1,
    S_WRITE_WAITING  = 3'd2,
    S_READ_RELAYING  = 3'd3,
    S_WRITE_RELAYING = 3'd4
  } state_e;

  state_e               state_q [NUM_CHANNELS];
  logic [c_PTR_W-1:0]   owner_q [NUM_CHANNELS];
  logic [c_CNT_W-1:0]   cnt_q   [NUM_CHANNELS];
  logic [c_PTR_W-1:0]   rr_q, rr_d;
  logic [NUM_CONSUMERS-1:0] serving_q, serving_d;

  logic [NUM_CONSUMERS-1:0]           consumer_read_ready_q;
  logic [DATA_BITS*NUM_CONSUMERS-1:0] consumer_read_data_q;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready_q;
  logic [NUM_CONSUMERS-1:0]           consumer_error_q;
  logic [NUM_CHANNELS-1:0]            mem_read_valid_q;
  logic [ADDR_BITS*NUM_CHANNELS-1:0]  mem_read_address_q;
  logic [NUM_CHANNELS-1:0]            mem_write_valid_q;
  logic [ADDR_BITS*NUM_CHANNELS-1:0]  mem_write_address_q;
  logic [DATA_BITS*NUM_CHANNELS-1:0]  mem_write_data_q;

  // Grant decision per channel, computed for all channels in one cycle.
  logic                 w_gnt_v   [NUM_CHANNELS];
  logic                 w_gnt_rd  [NUM_CHANNELS];
  logic [c_PTR_W-1:0]   w_gnt_idx [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] w_wr_req;
  logic [NUM_CONSUMERS-1:0] w_pend;
  logic [NUM_CONSUMERS-1:0] w_taken;
  logic [NUM_CONSUMERS-1:0] w_release;
  int                       w_cand;

  // A read-only controller simply never sees write requests.
  assign w_wr_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
  assign w_pend   = consumer_read_valid | w_wr_req;

  always_comb begin
    w_taken   = serving_q;
    w_release = '0;
    rr_d      = rr_q;
    w_cand    = 0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      w_gnt_v[ch]   = 1'b0;
      w_gnt_rd[ch]  = 1'b0;
      w_gnt_idx[ch] = '0;
      if (state_q[ch] == S_IDLE) begin
        // Scan from farthest to nearest so the consumer closest to rr_q
        // (in circular order) is the one left selected.
        for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
          w_cand = (int'(rr_q) + k) % NUM_CONSUMERS;
          if (w_pend[w_cand] && !w_taken[w_cand]) begin
            w_gnt_v[ch]   = 1'b1;
            w_gnt_rd[ch]  = consumer_read_valid[w_cand];
            w_gnt_idx[ch] = c_PTR_W'(w_cand);
          end
        end
        // Later channels see this consumer as taken; the last granting
        // channel determines the new round-robin start point.
        if (w_gnt_v[ch]) begin
          w_taken[w_gnt_idx[ch]] = 1'b1;
          rr_d = c_PTR_W'((int'(w_gnt_idx[ch]) + 1) % NUM_CONSUMERS);
        end
      end
      if (state_q[ch] == S_READ_RELAYING && !consumer_read_valid[owner_q[ch]])
        w_release[owner_q[ch]] = 1'b1;
      if (state_q[ch] == S_WRITE_RELAYING && !consumer_write_valid[owner_q[ch]])
        w_release[owner_q[ch]] = 1'b1;
    end
    serving_d = w_taken & ~w_release;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q                   <= '0;
      serving_q              <= '0;
      consumer_read_ready_q  <= '0;
      consumer_read_data_q   <= '0;
      consumer_write_ready_q <= '0;
      consumer_error_q       <= '0;
      mem_read_valid_q       <= '0;
      mem_read_address_q     <= '0;
      mem_write_valid_q      <= '0;
      mem_write_address_q    <= '0;
      mem_write_data_q       <= '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= S_IDLE;
        owner_q[ch] <= '0;
        cnt_q[ch]   <= '0;
      end
    end else begin
      rr_q      <= rr_d;
      serving_q <= serving_d;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        case (state_q[ch])
          S_IDLE: begin
            if (w_gnt_v[ch]) begin
              owner_q[ch] <= w_gnt_idx[ch];
              cnt_q[ch]   <= '0;
              if (w_gnt_rd[ch]) begin
                mem_read_valid_q[ch] <= 1'b1;
                mem_read_address_q[ch*ADDR_BITS +: ADDR_BITS] <=
                  consumer_read_address[w_gnt_idx[ch]*ADDR_BITS +: ADDR_BITS];
                state_q[ch] <= S_READ_WAITING;
              end else begin
                mem_write_valid_q[ch] <= 1'b1;
                mem_write_address_q[ch*ADDR_BITS +: ADDR_BITS] <=
                  consumer_write_address[w_gnt_idx[ch]*ADDR_BITS +: ADDR_BITS];
                mem_write_data_q[ch*DATA_BITS +: DATA_BITS] <=
                  consumer_write_data[w_gnt_idx[ch]*DATA_BITS +: DATA_BITS];
                state_q[ch] <= S_WRITE_WAITING;
              end
            end
          end
          S_READ_WAITING: begin
            // A response in the timeout cycle takes priority over the error.
            if (mem_read_ready[ch]) begin
              mem_read_valid_q[ch] <= 1'b0;
              consumer_read_data_q[owner_q[ch]*DATA_BITS +: DATA_BITS] <=
                mem_read_data[ch*DATA_BITS +: DATA_BITS];
              consumer_read_ready_q[owner_q[ch]] <= 1'b1;
              state_q[ch] <= S_READ_RELAYING;
            end else if (TIMEOUT_CYCLES > 0 &&
                         (int'(cnt_q[ch]) + 1) == TIMEOUT_CYCLES) begin
              mem_read_valid_q[ch] <= 1'b0;
              consumer_read_data_q[owner_q[ch]*DATA_BITS +: DATA_BITS] <= '0;
              consumer_read_ready_q[owner_q[ch]] <= 1'b1;
              consumer_error_q[owner_q[ch]]      <= 1'b1;
              state_q[ch] <= S_READ_RELAYING;
            end else begin
              cnt_q[ch] <= cnt_q[ch] + 1'b1;
            end
          end
          S_WRITE_WAITING: begin
            if (mem_write_ready[ch]) begin
              mem_write_valid_q[ch] <= 1'b0;
              consumer_write_ready_q[owner_q[ch]] <= 1'b1;
              state_q[ch] <= S_WRITE_RELAYING;
            end else if (TIMEOUT_CYCLES > 0 &&
                         (int'(cnt_q[ch]) + 1) == TIMEOUT_CYCLES) begin
              mem_write_valid_q[ch] <= 1'b0;
              consumer_write_ready_q[owner_q[ch]] <= 1'b1;
              consumer_error_q[owner_q[ch]]       <= 1'b1;
              state_q[ch] <= S_WRITE_RELAYING;
            end else begin
              cnt_q[ch] <= cnt_q[ch] + 1'b1;
            end
          end
          S_READ_RELAYING: begin
            if (!consumer_read_valid[owner_q[ch]]) begin
              consumer_read_ready_q[owner_q[ch]] <= 1'b0;
              consumer_error_q[owner_q[ch]]      <= 1'b0;
              state_q[ch] <= S_IDLE;
            end
          end
          S_WRITE_RELAYING: begin
            if (!consumer_write_valid[owner_q[ch]]) begin
              consumer_write_ready_q[owner_q[ch]] <= 1'b0;
              consumer_error_q[owner_q[ch]]       <= 1'b0;
              state_q[ch] <= S_IDLE;
            end
          end
          default: state_q[ch] <= S_IDLE;
        endcase
      end
    end
  end

  assign consumer_read_ready = consumer_read_ready_q;
  assign consumer_read_data  = consumer_read_data_q;
  assign consumer_error      = consumer_error_q;
  assign mem_read_valid      = mem_read_valid_q;
  assign mem_read_address    = mem_read_address_q;

  generate
    if (WRITE_ENABLE != 0) begin : g_wr_on
      assign consumer_write_ready = consumer_write_ready_q;
      assign mem_write_valid      = mem_write_valid_q;
      assign mem_write_address    = mem_write_address_q;
      assign mem_write_data       = mem_write_data_q;
    end else begin : g_wr_off
      assign consumer_write_ready = '0;
      assign mem_write_valid      = '0;
      assign mem_write_address    = '0;
      assign mem_write_data       = '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_controller_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_controller_rr                                          |
// | Purpose  : Self-checking bench: instance A (1 channel, writes, timeout 8) |
// |            and instance B (2 channels, read-only, no timeout).           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mem_controller_rr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- instance A ----------------
  logic [3:0]  a_rv, a_crr, a_wv, a_cwr, a_err;
  logic [31:0] a_raddr, a_rdata, a_waddr, a_wdata;
  logic [0:0]  a_mrv, a_mrr, a_mwv, a_mwr;
  logic [7:0]  a_maddr, a_mrdata, a_mwaddr, a_mwdata;

  // Memory model: read data is address + 1.
  assign a_mrdata = a_maddr + 8'd1;

  mem_controller_rr #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1),
    .WRITE_ENABLE(1), .TIMEOUT_CYCLES(8)
  ) u_a (
    .clk(clk), .reset(rst),
    .consumer_read_valid(a_rv), .consumer_read_address(a_raddr),
    .consumer_read_ready(a_crr), .consumer_read_data(a_rdata),
    .consumer_write_valid(a_wv), .consumer_write_address(a_waddr),
    .consumer_write_data(a_wdata), .consumer_write_ready(a_cwr),
    .consumer_error(a_err),
    .mem_read_valid(a_mrv), .mem_read_address(a_maddr),
    .mem_read_ready(a_mrr), .mem_read_data(a_mrdata),
    .mem_write_valid(a_mwv), .mem_write_address(a_mwaddr),
    .mem_write_data(a_mwdata), .mem_write_ready(a_mwr)
  );

  // ---------------- instance B ----------------
  logic [3:0]  b_rv, b_crr, b_wv, b_cwr, b_err;
  logic [31:0] b_raddr, b_rdata, b_waddr, b_wdata;
  logic [1:0]  b_mrv, b_mrr, b_mwv, b_mwr;
  logic [15:0] b_maddr, b_mrdata, b_mwaddr, b_mwdata;

  assign b_mrdata = {b_maddr[15:8] + 8'd1, b_maddr[7:0] + 8'd1};

  mem_controller_rr #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2),
    .WRITE_ENABLE(0), .TIMEOUT_CYCLES(0)
  ) u_b (
    .clk(clk), .reset(rst),
    .consumer_read_valid(b_rv), .consumer_read_address(b_raddr),
    .consumer_read_ready(b_crr), .consumer_read_data(b_rdata),
    .consumer_write_valid(b_wv), .consumer_write_address(b_waddr),
    .consumer_write_data(b_wdata), .consumer_write_ready(b_cwr),
    .consumer_error(b_err),
    .mem_read_valid(b_mrv), .mem_read_address(b_maddr),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrdata),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwaddr),
    .mem_write_data(b_mwdata), .mem_write_ready(b_mwr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One record per clock: inputs applied before the edge, outputs expected after.
  typedef struct {
    logic [3:0] rv;
    logic [3:0] wv;
    logic       mrr;
    logic       mwr;
    logic       exp_mrv;
    logic       exp_mwv;
    int         exp_idx;
    logic [3:0] exp_crr;
    logic [3:0] exp_cwr;
  } vec_t;

  function automatic vec_t mk(logic [3:0] rv, logic [3:0] wv, logic mrr, logic mwr,
                              logic emrv, logic emwv, int eidx,
                              logic [3:0] ecrr, logic [3:0] ecwr);
    vec_t v;
    v.rv = rv; v.wv = wv; v.mrr = mrr; v.mwr = mwr;
    v.exp_mrv = emrv; v.exp_mwv = emwv; v.exp_idx = eidx;
    v.exp_crr = ecrr; v.exp_cwr = ecwr;
    return v;
  endfunction

  vec_t tbl [26];

  initial begin
    // Round-robin reads 0,1,2,3,0 with continuously re-raised valids.
    tbl[0]  = mk(4'b1111, 4'b0000, 0, 0, 1, 0, 0, 4'b0000, 4'b0000);
    tbl[1]  = mk(4'b1111, 4'b0000, 1, 0, 0, 0, 0, 4'b0001, 4'b0000);
    tbl[2]  = mk(4'b1110, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    tbl[3]  = mk(4'b1111, 4'b0000, 0, 0, 1, 0, 1, 4'b0000, 4'b0000);
    tbl[4]  = mk(4'b1111, 4'b0000, 1, 0, 0, 0, 1, 4'b0010, 4'b0000);
    tbl[5]  = mk(4'b1101, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    tbl[6]  = mk(4'b1111, 4'b0000, 0, 0, 1, 0, 2, 4'b0000, 4'b0000);
    tbl[7]  = mk(4'b1111, 4'b0000, 1, 0, 0, 0, 2, 4'b0100, 4'b0000);
    tbl[8]  = mk(4'b1011, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    tbl[9]  = mk(4'b1111, 4'b0000, 0, 0, 1, 0, 3, 4'b0000, 4'b0000);
    tbl[10] = mk(4'b1111, 4'b0000, 1, 0, 0, 0, 3, 4'b1000, 4'b0000);
    tbl[11] = mk(4'b0111, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    tbl[12] = mk(4'b1111, 4'b0000, 0, 0, 1, 0, 0, 4'b0000, 4'b0000);
    tbl[13] = mk(4'b1111, 4'b0000, 1, 0, 0, 0, 0, 4'b0001, 4'b0000);
    tbl[14] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    // Write from consumer 2 (0x3C / 0xA5), ready held until valid drops.
    tbl[15] = mk(4'b0000, 4'b0100, 0, 0, 0, 1, 2, 4'b0000, 4'b0000);
    tbl[16] = mk(4'b0000, 4'b0100, 0, 0, 0, 1, 2, 4'b0000, 4'b0000);
    tbl[17] = mk(4'b0000, 4'b0100, 0, 1, 0, 0, 0, 4'b0000, 4'b0100);
    tbl[18] = mk(4'b0000, 4'b0100, 0, 0, 0, 0, 0, 4'b0000, 4'b0100);
    tbl[19] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    // Consumer 1 with read and write together: read first, then the write.
    tbl[20] = mk(4'b0010, 4'b0010, 0, 0, 1, 0, 1, 4'b0000, 4'b0000);
    tbl[21] = mk(4'b0010, 4'b0010, 1, 0, 0, 0, 1, 4'b0010, 4'b0000);
    tbl[22] = mk(4'b0000, 4'b0010, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    tbl[23] = mk(4'b0000, 4'b0010, 0, 0, 0, 1, 1, 4'b0000, 4'b0000);
    tbl[24] = mk(4'b0000, 4'b0010, 0, 1, 0, 0, 0, 4'b0000, 4'b0010);
    tbl[25] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);

    for (int i = 0; i < 4; i++) begin
      a_raddr[i*8 +: 8] = 8'h10 + 8'(i);
      a_waddr[i*8 +: 8] = 8'h3A + 8'(i);
      a_wdata[i*8 +: 8] = 8'hA3 + 8'(i);
      b_raddr[i*8 +: 8] = 8'h10 + 8'(i);
      b_waddr[i*8 +: 8] = 8'h50 + 8'(i);
      b_wdata[i*8 +: 8] = 8'h60 + 8'(i);
    end
    a_rv = '0; a_wv = '0; a_mrr = '0; a_mwr = '0;
    b_rv = '0; b_wv = '0; b_mrr = '0; b_mwr = '0;

    // ---------------- reset state ----------------
    rst = 1'b1;
    step();
    step();
    chk("reset_a_mrv", 32'(a_mrv), 0);
    chk("reset_a_mwv", 32'(a_mwv), 0);
    chk("reset_a_crr", 32'(a_crr), 0);
    chk("reset_a_cwr", 32'(a_cwr), 0);
    chk("reset_a_err", 32'(a_err), 0);
    chk("reset_a_rdata", a_rdata, 0);
    chk("reset_b_mrv", 32'(b_mrv), 0);
    rst = 1'b0;

    // ---------------- table-driven vectors on A ----------------
    for (int i = 0; i < 26; i++) begin
      a_rv  = tbl[i].rv;
      a_wv  = tbl[i].wv;
      a_mrr = tbl[i].mrr;
      a_mwr = tbl[i].mwr;
      step();
      chk($sformatf("v%0d_mrv", i), 32'(a_mrv), 32'(tbl[i].exp_mrv));
      chk($sformatf("v%0d_mwv", i), 32'(a_mwv), 32'(tbl[i].exp_mwv));
      chk($sformatf("v%0d_crr", i), 32'(a_crr), 32'(tbl[i].exp_crr));
      chk($sformatf("v%0d_cwr", i), 32'(a_cwr), 32'(tbl[i].exp_cwr));
      chk($sformatf("v%0d_err", i), 32'(a_err), 0);
      if (tbl[i].exp_mrv)
        chk($sformatf("v%0d_maddr", i), 32'(a_maddr), 32'h10 + 32'(tbl[i].exp_idx));
      if (tbl[i].exp_mwv) begin
        chk($sformatf("v%0d_mwaddr", i), 32'(a_mwaddr), 32'h3A + 32'(tbl[i].exp_idx));
        chk($sformatf("v%0d_mwdata", i), 32'(a_mwdata), 32'hA3 + 32'(tbl[i].exp_idx));
      end
      for (int j = 0; j < 4; j++)
        if (tbl[i].exp_crr[j])
          chk($sformatf("v%0d_rdata%0d", i, j), 32'(a_rdata[j*8 +: 8]), 32'h11 + 32'(j));
    end

    // ---------------- timeout: memory never answers ----------------
    a_rv = 4'b0001; a_wv = '0; a_mrr = '0; a_mwr = '0;
    step();
    chk("to_grant_mrv", 32'(a_mrv), 1);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("to_wait%0d_mrv", k), 32'(a_mrv), 1);
      chk($sformatf("to_wait%0d_crr", k), 32'(a_crr), 0);
    end
    step();
    chk("to_fire_mrv", 32'(a_mrv), 0);
    chk("to_fire_crr", 32'(a_crr), 32'b0001);
    chk("to_fire_err", 32'(a_err), 32'b0001);
    chk("to_fire_data", 32'(a_rdata[7:0]), 0);
    step();
    chk("to_hold_err", 32'(a_err), 32'b0001);
    a_rv = 4'b0000;
    step();
    chk("to_clear_crr", 32'(a_crr), 0);
    chk("to_clear_err", 32'(a_err), 0);

    // ---------------- ready arriving on the timeout cycle ----------------
    a_rv = 4'b0001;
    step();
    chk("tr_grant_mrv", 32'(a_mrv), 1);
    for (int k = 1; k <= 7; k++) step();
    chk("tr_wait7_crr", 32'(a_crr), 0);
    a_mrr = 1'b1;
    step();
    chk("tr_crr", 32'(a_crr), 32'b0001);
    chk("tr_err", 32'(a_err), 0);
    chk("tr_data", 32'(a_rdata[7:0]), 32'h11);
    a_mrr = 1'b0; a_rv = 4'b0000;
    step();
    chk("tr_clear_crr", 32'(a_crr), 0);

    // ---------------- reset during READ_WAITING ----------------
    a_rv = 4'b0001;
    step();
    step();
    chk("rw_waiting_mrv", 32'(a_mrv), 1);
    rst = 1'b1;
    step();
    chk("rw_reset_mrv", 32'(a_mrv), 0);
    chk("rw_reset_crr", 32'(a_crr), 0);
    chk("rw_reset_err", 32'(a_err), 0);
    chk("rw_reset_rdata", a_rdata, 0);
    rst = 1'b0;
    a_rv = 4'b0011;
    step();
    chk("rw_regrant_mrv", 32'(a_mrv), 1);
    chk("rw_regrant_addr", 32'(a_maddr), 32'h10);
    a_mrr = 1'b1;
    step();
    chk("rw_regrant_crr", 32'(a_crr), 32'b0001);
    a_mrr = 1'b0; a_rv = 4'b0000;
    step();

    // ---------------- B: two channels grant 1 and 3 together ----------------
    b_rv = 4'b1010;
    step();
    chk("dc_mrv", 32'(b_mrv), 32'b11);
    chk("dc_ch0_addr", 32'(b_maddr[7:0]), 32'h11);
    chk("dc_ch1_addr", 32'(b_maddr[15:8]), 32'h13);
    b_mrr = 2'b11;
    step();
    chk("dc_crr", 32'(b_crr), 32'b1010);
    chk("dc_data1", 32'(b_rdata[15:8]), 32'h12);
    chk("dc_data3", 32'(b_rdata[31:24]), 32'h14);
    b_mrr = 2'b00; b_rv = 4'b0000;
    step();
    chk("dc_clear_crr", 32'(b_crr), 0);
    // Pointer must now be 0: all request, channels take 0 and 1.
    b_rv = 4'b1111;
    step();
    chk("dc_rr_mrv", 32'(b_mrv), 32'b11);
    chk("dc_rr_ch0", 32'(b_maddr[7:0]), 32'h10);
    chk("dc_rr_ch1", 32'(b_maddr[15:8]), 32'h11);
    b_mrr = 2'b11;
    step();
    chk("dc_rr_crr", 32'(b_crr), 32'b0011);
    b_mrr = 2'b00; b_rv = 4'b0000;
    step();

    // ---------------- B: read-only mode ignores writes ----------------
    b_wv = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      b_rv  = (k == 2 || k == 3) ? 4'b0010 : 4'b0000;
      b_mrr = (k == 3) ? 2'b01 : 2'b00;
      step();
      chk($sformatf("ro%0d_mwv", k), 32'(b_mwv), 0);
      chk($sformatf("ro%0d_cwr", k), 32'(b_cwr), 0);
      chk($sformatf("ro%0d_mwaddr", k), 32'(b_mwaddr), 0);
      if (k == 2) begin
        chk("ro_read_mrv", 32'(b_mrv), 32'b01);
        chk("ro_read_addr", 32'(b_maddr[7:0]), 32'h11);
      end
      if (k == 3) begin
        chk("ro_read_crr", 32'(b_crr), 32'b0010);
        chk("ro_read_data", 32'(b_rdata[15:8]), 32'h12);
      end
      if (k == 4) chk("ro_read_clear", 32'(b_crr), 0);
    end
    b_wv = 4'b0000;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_controller_rr.md
Name: mem_controller_rr

Overview:
- Parametrised successor of the data/program memory controller; arbitrates read/write requests from NUM_CONSUMERS fetchers/LSUs onto NUM_CHANNELS global-memory channels.
- Adds three things over the previous controller: round-robin fairness across consumers, a compile-time read-only mode, and a per-channel response timeout that returns an error to the consumer instead of hanging.
- Sits between the cores and the external memory interface; one instance for program memory (read-only) and one for data memory.

Parameters:
ADDR_BITS, 8, address width
DATA_BITS, 8, data width (16 for program memory)
NUM_CONSUMERS, 4, number of requesters (>=1)
NUM_CHANNELS, 1, concurrent memory channels (1..NUM_CONSUMERS)
WRITE_ENABLE, 1, 0 = read-only controller
TIMEOUT_CYCLES, 0, max cycles waiting on memory; 0 disables timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
consumer_read_valid  in  NUM_CONSUMERS  read request per consumer
consumer_read_address  in  ADDR_BITS x NUM_CONSUMERS  read address
consumer_read_ready  out  NUM_CONSUMERS  read response valid
consumer_read_data  out  DATA_BITS x NUM_CONSUMERS  read data
consumer_write_valid  in  NUM_CONSUMERS  write request
consumer_write_address  in  ADDR_BITS x NUM_CONSUMERS  write address
consumer_write_data  in  DATA_BITS x NUM_CONSUMERS  write data
consumer_write_ready  out  NUM_CONSUMERS  write acknowledge
consumer_error  out  NUM_CONSUMERS  high with ready when request timed out
mem_read_valid  out  NUM_CHANNELS  read request to memory
mem_read_address  out  ADDR_BITS x NUM_CHANNELS  memory read address
mem_read_ready  in  NUM_CHANNELS  memory read done
mem_read_data  in  DATA_BITS x NUM_CHANNELS  memory read data
mem_write_valid  out  NUM_CHANNELS  write request to memory
mem_write_address  out  ADDR_BITS x NUM_CHANNELS  memory write address
mem_write_data  out  DATA_BITS x NUM_CHANNELS  memory write data
mem_write_ready  in  NUM_CHANNELS  memory write done

Behaviour:
- One clock domain, clk; reset is synchronous and active-high. On reset, every output, the rr pointer, all channel states, the serving mask and the timeout counters go to 0. A reset mid-transaction abandons it; memory sees valid drop on the next edge.
- Per-channel FSM: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- Grant (IDLE):
  - Channels are evaluated in index order 0..NUM_CHANNELS-1 in the same cycle.
  - Each idle channel takes the first consumer, searching circularly from rr_ptr, that has a pending request and is not already being served (including by a lower channel granted this cycle).
  - Read takes precedence over write for the same consumer.
  - Grant registers mem_*_valid, address and data (write) and enters *_WAITING, so the memory request appears 1 cycle after consumer valid.
  - If any grant occurs, rr_ptr <= (highest-priority-order last granted consumer + 1) mod NUM_CONSUMERS; otherwise rr_ptr holds.
- READ_WAITING:
  - On mem_read_ready: drop mem_read_valid, set consumer_read_data <= mem_read_data and consumer_read_ready <= 1, go to READ_RELAYING.
  - Timeout: when TIMEOUT_CYCLES>0 and the wait counter reaches TIMEOUT_CYCLES with no ready, drop mem_read_valid, set data <= 0, ready <= 1, consumer_error <= 1, go to READ_RELAYING.
  - The counter clears on entry to WAITING. If ready arrives in the same cycle as the timeout, ready wins and no error is raised.
- WRITE_WAITING: same as READ_WAITING using mem_write_ready and consumer_write_ready, with identical timeout handling.
- *_RELAYING: hold ready (and error) until the consumer deasserts its valid. On that edge, clear ready and error, release the consumer from the serving mask and go to IDLE. The same channel may grant again the following cycle.
- WRITE_ENABLE=0: write requests are never granted; mem_write_valid, mem_write_address, mem_write_data and consumer_write_ready are constant 0.
- Consumers must hold valid, address and data stable until ready. Address and data are sampled at grant only.
- Data paths pass through unmodified; there is no width conversion. rr_ptr is $clog2(NUM_CONSUMERS) bits wide, minimum 1. The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits wide.
- Memory must respond with ready for a single request; the controller never holds more than one request per channel.

Test Plan:
1. NUM_CONSUMERS=4, NUM_CHANNELS=1: all four consumers request reads continuously. Grants must run in order 0,1,2,3,0 with no starvation, and each consumer receives its own data (mem_read_data = address+1).
2. NUM_CHANNELS=2: consumers 1 and 3 raise read valid together. Channels 0 and 1 grant distinct consumers (1 then 3) in the same cycle, both mem_read_valid rise 1 cycle later, and rr_ptr becomes 0.
3. Write from consumer 2: addr 0x3C, data 0xA5. mem_write_valid rises with 0x3C/0xA5. After mem_write_ready, consumer_write_ready[2]=1 is held until valid drops, then cleared on the next edge.
4. TIMEOUT_CYCLES=8, memory never responds to a read from consumer 0. Exactly 8 waiting cycles later: mem_read_valid=0, consumer_read_ready[0]=1, consumer_error[0]=1, data=0. Also apply ready on the 8th cycle itself: the read completes without error.
5. WRITE_ENABLE=0: drive a write on consumer 1 for 20 cycles. No mem_write_valid and no write_ready; a read from consumer 1 alongside it is still served.
6. Assert reset while in READ_WAITING. The next cycle all outputs are 0 and the FSMs are IDLE; a fresh request is then granted normally.
